tutorial_sort_stepper: RTL and testbench

//  Reads the six 3-bit tutorial array values produced by the tutorial input engine.

---
 rtl/tutorial_sort_stepper_pkg.sv | 22 ++
 rtl/tutorial_step_timer.sv | 37 +++
 rtl/tutorial_sort_stepper.sv | 169 ++++++++++++++++
 tb/tb_tutorial_sort_stepper.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tutorial_sort_stepper_pkg.sv
// Shared definitions for the tutorial insertion-sort stepper: phase encodings and array geometry.
package tutorial_sort_stepper_pkg;

    localparam int unsigned NUM_ELEMS     = 6;
    localparam int unsigned DEFAULT_VAL_W = 3;
    localparam int unsigned LAST_IDX      = NUM_ELEMS - 1;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_PICK    = 3'd1,
        PH_COMPARE = 3'd2,
        PH_SHIFT   = 3'd3,
        PH_INSERT  = 3'd4,
        PH_DONE    = 3'd5
    } phase_e;

    // A sort is in progress and will accept steps.
    function automatic logic phase_active(input phase_e ph);
        return (ph != PH_IDLE) && (ph != PH_DONE);
    endfunction

endpackage

// File: rtl/tutorial_step_timer.sv
// Auto-step divider: pulses tick_o once every Cycles enabled clocks; clear_i restarts the count.
module tutorial_step_timer #(
    parameter int unsigned Cycles = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [31:0] LastCnt = 32'(Cycles - 1);

    logic [31:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tutorial_sort_stepper.sv
// Insertion sort over six small values, advanced one micro-step per step request.
// Optional TUTORIAL_AUTO_STEP_EN adds an internal divider that generates steps on its own.
module tutorial_sort_stepper
    import tutorial_sort_stepper_pkg::*;
#(
    parameter int unsigned VAL_W = DEFAULT_VAL_W,
    parameter int unsigned CNT_W = 5
`ifdef TUTORIAL_AUTO_STEP_EN
    ,
    parameter int unsigned AUTO_STEP_CYCLES = 100_000_000
`endif
) (
    input  logic             clk_100mhz,
    input  logic             reset_n,
    input  logic             load_pulse,
    input  logic             step_pulse,
    input  logic [VAL_W-1:0] tut_array_0,
    input  logic [VAL_W-1:0] tut_array_1,
    input  logic [VAL_W-1:0] tut_array_2,
    input  logic [VAL_W-1:0] tut_array_3,
    input  logic [VAL_W-1:0] tut_array_4,
    input  logic [VAL_W-1:0] tut_array_5,
    output logic [VAL_W-1:0] sort_array_0,
    output logic [VAL_W-1:0] sort_array_1,
    output logic [VAL_W-1:0] sort_array_2,
    output logic [VAL_W-1:0] sort_array_3,
    output logic [VAL_W-1:0] sort_array_4,
    output logic [VAL_W-1:0] sort_array_5,
    output logic [VAL_W-1:0] key_val,
    output logic [2:0]       outer_idx,
    output logic [2:0]       hole_idx,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] shift_count,
    output logic             done
);

    logic [VAL_W-1:0] arr_q [NUM_ELEMS];
    logic [VAL_W-1:0] arr_d [NUM_ELEMS];
    logic [VAL_W-1:0] tut_arr [NUM_ELEMS];
    logic [VAL_W-1:0] key_q, key_d;
    logic [2:0]       outer_q, outer_d;
    logic [2:0]       hole_q, hole_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] shift_q, shift_d;
    phase_e           phase_q, phase_d;
    logic             done_q, done_d;
    logic             auto_step;
    logic             step;

    assign tut_arr[0] = tut_array_0;
    assign tut_arr[1] = tut_array_1;
    assign tut_arr[2] = tut_array_2;
    assign tut_arr[3] = tut_array_3;
    assign tut_arr[4] = tut_array_4;
    assign tut_arr[5] = tut_array_5;

`ifdef TUTORIAL_AUTO_STEP_EN
    tutorial_step_timer #(
        .Cycles (AUTO_STEP_CYCLES)
    ) u_step_timer (
        .clk_i    (clk_100mhz),
        .rst_ni   (reset_n),
        .clear_i  (load_pulse),
        .enable_i (phase_active(phase_q)),
        .tick_o   (auto_step)
    );
`else
    assign auto_step = 1'b0;
`endif

    assign step = step_pulse | auto_step;

    always_comb begin
        arr_d   = arr_q;
        key_d   = key_q;
        outer_d = outer_q;
        hole_d  = hole_q;
        cmp_d   = cmp_q;
        shift_d = shift_q;
        phase_d = phase_q;

        if (load_pulse) begin
            for (int k = 0; k < NUM_ELEMS; k++) begin
                arr_d[k] = tut_arr[k];
            end
            outer_d = 3'd1;
            hole_d  = 3'd0;
            key_d   = '0;
            cmp_d   = '0;
            shift_d = '0;
            phase_d = PH_PICK;
        end else if (step) begin
            case (phase_q)
                PH_PICK: begin
                    key_d   = arr_q[outer_q];
                    hole_d  = outer_q;
                    phase_d = PH_COMPARE;
                end
                PH_COMPARE: begin
                    if (hole_q != 3'd0) begin
                        cmp_d = cmp_q + 1'b1;
                        // Strict compare keeps equal keys in their original order.
                        phase_d = (arr_q[hole_q - 3'd1] > key_q) ? PH_SHIFT : PH_INSERT;
                    end else begin
                        phase_d = PH_INSERT;
                    end
                end
                PH_SHIFT: begin
                    arr_d[hole_q] = arr_q[hole_q - 3'd1];
                    hole_d        = hole_q - 3'd1;
                    shift_d       = shift_q + 1'b1;
                    phase_d       = PH_COMPARE;
                end
                PH_INSERT: begin
                    arr_d[hole_q] = key_q;
                    if (outer_q == 3'(LAST_IDX)) begin
                        phase_d = PH_DONE;
                    end else begin
                        outer_d = outer_q + 3'd1;
                        phase_d = PH_PICK;
                    end
                end
                default: ;
            endcase
        end

        done_d = (phase_d == PH_DONE);
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_ELEMS; k++) begin
                arr_q[k] <= '0;
            end
            key_q   <= '0;
            outer_q <= '0;
            hole_q  <= '0;
            cmp_q   <= '0;
            shift_q <= '0;
            phase_q <= PH_IDLE;
            done_q  <= 1'b0;
        end else begin
            arr_q   <= arr_d;
            key_q   <= key_d;
            outer_q <= outer_d;
            hole_q  <= hole_d;
            cmp_q   <= cmp_d;
            shift_q <= shift_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign sort_array_0 = arr_q[0];
    assign sort_array_1 = arr_q[1];
    assign sort_array_2 = arr_q[2];
    assign sort_array_3 = arr_q[3];
    assign sort_array_4 = arr_q[4];
    assign sort_array_5 = arr_q[5];
    assign key_val      = key_q;
    assign outer_idx    = outer_q;
    assign hole_idx     = hole_q;
    assign phase        = phase_q;
    assign cmp_count    = cmp_q;
    assign shift_count  = shift_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tutorial_sort_stepper.sv
// Directed self-checking bench for tutorial_sort_stepper; the auto-step scenario runs when
// TUTORIAL_AUTO_STEP_EN is defined, the manual-step scenarios otherwise.
module tb_tutorial_sort_stepper;

    logic       clk_100mhz = 1'b0;
    logic       reset_n;
    logic       load_pulse;
    logic       step_pulse;
    logic [2:0] tin [6];
    logic [2:0] sa [6];
    logic [2:0] key_val, outer_idx, hole_idx, phase;
    logic [4:0] cmp_count, shift_count;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    tutorial_sort_stepper #(
        .VAL_W (3),
        .CNT_W (5)
`ifdef TUTORIAL_AUTO_STEP_EN
        ,
        .AUTO_STEP_CYCLES (4)
`endif
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .reset_n      (reset_n),
        .load_pulse   (load_pulse),
        .step_pulse   (step_pulse),
        .tut_array_0  (tin[0]),
        .tut_array_1  (tin[1]),
        .tut_array_2  (tin[2]),
        .tut_array_3  (tin[3]),
        .tut_array_4  (tin[4]),
        .tut_array_5  (tin[5]),
        .sort_array_0 (sa[0]),
        .sort_array_1 (sa[1]),
        .sort_array_2 (sa[2]),
        .sort_array_3 (sa[3]),
        .sort_array_4 (sa[4]),
        .sort_array_5 (sa[5]),
        .key_val      (key_val),
        .outer_idx    (outer_idx),
        .hole_idx     (hole_idx),
        .phase        (phase),
        .cmp_count    (cmp_count),
        .shift_count  (shift_count),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic set_inputs(input logic [2:0] v0, v1, v2, v3, v4, v5);
        tin[0] = v0; tin[1] = v1; tin[2] = v2;
        tin[3] = v3; tin[4] = v4; tin[5] = v5;
    endtask

    task automatic load_vals(input logic [2:0] v0, v1, v2, v3, v4, v5);
        set_inputs(v0, v1, v2, v3, v4, v5);
        load_pulse = 1'b1;
        cycle();
        load_pulse = 1'b0;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            step_pulse = 1'b1;
            cycle();
            step_pulse = 1'b0;
        end
    endtask

    task automatic check_arr(input string tag, input logic [2:0] e0, e1, e2, e3, e4, e5);
        check_eq({tag, "_a0"}, 32'(sa[0]), 32'(e0));
        check_eq({tag, "_a1"}, 32'(sa[1]), 32'(e1));
        check_eq({tag, "_a2"}, 32'(sa[2]), 32'(e2));
        check_eq({tag, "_a3"}, 32'(sa[3]), 32'(e3));
        check_eq({tag, "_a4"}, 32'(sa[4]), 32'(e4));
        check_eq({tag, "_a5"}, 32'(sa[5]), 32'(e5));
    endtask

    task automatic check_all_zero(input string tag);
        check_arr(tag, 0, 0, 0, 0, 0, 0);
        check_eq({tag, "_key"},   32'(key_val),     32'd0);
        check_eq({tag, "_outer"}, 32'(outer_idx),   32'd0);
        check_eq({tag, "_hole"},  32'(hole_idx),    32'd0);
        check_eq({tag, "_phase"}, 32'(phase),       32'd0);
        check_eq({tag, "_cmp"},   32'(cmp_count),   32'd0);
        check_eq({tag, "_shift"}, 32'(shift_count), 32'd0);
        check_eq({tag, "_done"},  32'(done),        32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_pulse = 1'b0;
        step_pulse = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset_n = 1'b1;
        check_all_zero("reset");

        // Steps are ignored in IDLE.
        step_n(2);
        check_all_zero("idle_step");

`ifdef TUTORIAL_AUTO_STEP_EN
        begin
            int cyc;
            load_vals(2, 1, 0, 0, 0, 0);
            cycle(); cycle(); cycle();
            check_eq("auto_wait3_phase", 32'(phase), 32'd1);
            cycle();
            check_eq("auto_first_phase", 32'(phase), 32'd2);
            check_eq("auto_first_key", 32'(key_val), 32'd1);
            check_eq("auto_first_hole", 32'(hole_idx), 32'd1);
            // 33 steps at one per 4 cycles.
            cyc = 4;
            while (!done && cyc < 200) begin
                cycle();
                cyc++;
            end
            check_eq("auto_done_cycles", 32'(cyc), 32'd132);
            check_eq("auto_done", 32'(done), 32'd1);
            check_arr("auto_sorted", 0, 0, 0, 0, 1, 2);
            check_eq("auto_cmp", 32'(cmp_count), 32'd12);
            check_eq("auto_shift", 32'(shift_count), 32'd9);
            for (int i = 0; i < 20; i++) cycle();
            check_eq("auto_after_phase", 32'(phase), 32'd5);
            check_arr("auto_after", 0, 0, 0, 0, 1, 2);
            check_eq("auto_after_cmp", 32'(cmp_count), 32'd12);
            check_eq("auto_after_shift", 32'(shift_count), 32'd9);
        end
`else
        // Reverse-ordered input: worst case, 45 steps.
        load_vals(7, 6, 5, 4, 3, 2);
        check_eq("t1_load_phase", 32'(phase), 32'd1);
        check_eq("t1_load_outer", 32'(outer_idx), 32'd1);
        check_arr("t1_load", 7, 6, 5, 4, 3, 2);
        step_n(44);
        check_eq("t1_44_done", 32'(done), 32'd0);
        step_n(1);
        check_arr("t1_sorted", 2, 3, 4, 5, 6, 7);
        check_eq("t1_cmp", 32'(cmp_count), 32'd15);
        check_eq("t1_shift", 32'(shift_count), 32'd15);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_phase", 32'(phase), 32'd5);
        step_n(1);
        check_arr("t1_extra", 2, 3, 4, 5, 6, 7);
        check_eq("t1_extra_cmp", 32'(cmp_count), 32'd15);
        check_eq("t1_extra_shift", 32'(shift_count), 32'd15);
        check_eq("t1_extra_done", 32'(done), 32'd1);

        // Already sorted: three steps per pass.
        load_vals(1, 2, 3, 4, 5, 6);
        step_n(14);
        check_eq("t2_14_done", 32'(done), 32'd0);
        step_n(1);
        check_eq("t2_done", 32'(done), 32'd1);
        check_arr("t2_arr", 1, 2, 3, 4, 5, 6);
        check_eq("t2_cmp", 32'(cmp_count), 32'd5);
        check_eq("t2_shift", 32'(shift_count), 32'd0);

        // Duplicates: hole must stop at the first equal element.
        load_vals(3, 1, 3, 0, 1, 3);
        step_n(23);
        check_eq("t3_phase_ins", 32'(phase), 32'd4);
        check_eq("t3_hole_stop", 32'(hole_idx), 32'd2);
        check_eq("t3_key", 32'(key_val), 32'd1);
        check_eq("t3_cmp_mid", 32'(cmp_count), 32'd8);
        check_arr("t3_mid", 0, 1, 3, 3, 3, 3);
        step_n(4);
        check_eq("t3_done", 32'(done), 32'd1);
        check_arr("t3_sorted", 0, 1, 1, 3, 3, 3);
        check_eq("t3_cmp", 32'(cmp_count), 32'd9);
        check_eq("t3_shift", 32'(shift_count), 32'd6);

        // Load wins over a same-cycle step.
        load_vals(7, 6, 5, 4, 3, 2);
        step_n(7);
        set_inputs(1, 0, 3, 2, 5, 4);
        load_pulse = 1'b1;
        step_pulse = 1'b1;
        cycle();
        load_pulse = 1'b0;
        step_pulse = 1'b0;
        check_eq("t4_phase", 32'(phase), 32'd1);
        check_eq("t4_cmp", 32'(cmp_count), 32'd0);
        check_eq("t4_shift", 32'(shift_count), 32'd0);
        check_eq("t4_outer", 32'(outer_idx), 32'd1);
        check_eq("t4_hole", 32'(hole_idx), 32'd0);
        check_eq("t4_key", 32'(key_val), 32'd0);
        check_arr("t4_arr", 1, 0, 3, 2, 5, 4);
        set_inputs(7, 7, 7, 7, 7, 7);
        step_n(1);
        check_arr("t4_in_change", 1, 0, 3, 2, 5, 4);
        check_eq("t4_pick_key", 32'(key_val), 32'd0);
        check_eq("t4_pick_hole", 32'(hole_idx), 32'd1);

        // Reset in the middle of a shift.
        load_vals(7, 6, 5, 4, 3, 2);
        step_n(2);
        check_eq("t5_in_shift", 32'(phase), 32'd3);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check_all_zero("t5_reset");
        step_n(1);
        check_all_zero("t5_idle_step");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
